// File: rtl/stepper_move_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl_pkg
// Shared definitions for the stepper move sequencer:
//   - state_e      : controller states (IDLE / RUN / HOLD)
//   - PHASE_TABLE  : coil pattern per phase index, packed {A1,B1,A2,B2}
//   - DEF_MIN_PERIOD : default floor for the programmed step period
// No ports (package).
// -----------------------------------------------------------------------------
package stepper_move_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int DEF_MIN_PERIOD = 2;

   // Index 7 is the leftmost entry; each entry is {A1,B1,A2,B2}.
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1001,  // 7: B2+A1
      4'b0001,  // 6: B2
      4'b0011,  // 5: A2+B2
      4'b0010,  // 4: A2
      4'b0110,  // 3: B1+A2
      4'b0100,  // 2: B1
      4'b1100,  // 1: A1+B1
      4'b1000   // 0: A1
   };

   function automatic logic [3:0] phase_coils(input logic [2:0] idx);
      return PHASE_TABLE[idx];
   endfunction

endpackage

// File: rtl/stepper_move_ctrl_step_timer.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl_step_timer
// Loadable down-counter producing a one-cycle tick every P enabled cycles.
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   load_i    : load period_i as the new period and restart the count
//   period_i  : period in cycles (caller guarantees >= 1)
//   en_i      : count enable
//   tick_o    : high on the enabled cycle that completes a period
// -----------------------------------------------------------------------------
module stepper_move_ctrl_step_timer #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                en_i,
   output logic                tick_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_q;

   // Count of 1 means this cycle is the last of the period.
   assign tick_o = en_i && (cnt_q <= PERIOD_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = period_i;
      end else if (en_i) begin
         cnt_d = tick_o ? period_q : (cnt_q - PERIOD_W'(1));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         period_q <= period_i;
      end
   end

endmodule

// File: rtl/stepper_move_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_move_ctrl
// Command-driven move sequencer for a unipolar stepper driver.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   CMD_VALID/READY   : command handshake (taken when both high at a clock edge)
//   CMD_DIR           : 1 = forward (phase index increments)
//   CMD_HALF          : 1 = half-step (+/-1), 0 = full-step (+/-2)
//   CMD_STEPS         : number of steps (0 = no motion, DONE pulse only)
//   CMD_PERIOD        : cycles per step, clamped up to MIN_PERIOD
//   ABORT             : stop the current move (ignored outside RUN)
//   BUSY              : high while a move is running
//   DONE              : one-cycle pulse at end/abort/zero-step command
//   POS               : signed absolute position in half-steps
//   PHASE             : current phase index 0..7
//   A1, B1, A2, B2    : coil drives
// -----------------------------------------------------------------------------
module stepper_move_ctrl
   import stepper_move_ctrl_pkg::*;
#(
   parameter int STEPS_W     = 16,
   parameter int PERIOD_W    = 16,
   parameter int POS_W       = 24,
   parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter int HOLD_CYCLES = 1000000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic                    CMD_DIR,
   input  logic                    CMD_HALF,
   input  logic [STEPS_W-1:0]      CMD_STEPS,
   input  logic [PERIOD_W-1:0]     CMD_PERIOD,
   input  logic                    ABORT,
   output logic                    BUSY,
   output logic                    DONE,
   output logic signed [POS_W-1:0] POS,
   output logic [2:0]              PHASE,
   output logic                    A1,
   output logic                    B1,
   output logic                    A2,
   output logic                    B2
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   // Dwell counter counts down to 0, so HOLD_CYCLES cycles span load..0.
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
   localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

   state_e                  state_q, state_d;
   logic [2:0]              phase_q, phase_d;
   logic signed [POS_W-1:0] pos_q, pos_d;
   logic signed [POS_W-1:0] step_pos;
   logic [STEPS_W-1:0]      steps_q, steps_d;
   logic                    dir_q, dir_d;
   logic                    half_q, half_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic                    done_q, done_d;
   logic [3:0]              coils_q;
   logic                    busy_q, ready_q;
   logic                    accept, finish, tick, timer_load;
   logic [PERIOD_W-1:0]     period_clamped;

   assign accept         = CMD_VALID && ready_q;
   assign period_clamped = (CMD_PERIOD < MIN_P) ? MIN_P : CMD_PERIOD;

   stepper_move_ctrl_step_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_step_timer (
      .clk_i    (CLK),
      .rst_i    (RST),
      .load_i   (timer_load),
      .period_i (period_clamped),
      .en_i     (state_q == ST_RUN),
      .tick_o   (tick)
   );

   // Signed per-step displacement; its low 3 bits are the phase delta mod 8.
   always_comb begin
      case ({dir_q, half_q})
         2'b11:   step_pos = POS_W'(1);
         2'b10:   step_pos = POS_W'(2);
         2'b01:   step_pos = POS_W'(-1);
         default: step_pos = POS_W'(-2);
      endcase
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      pos_d      = pos_q;
      steps_d    = steps_q;
      dir_d      = dir_q;
      half_d     = half_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      timer_load = 1'b0;
      finish     = 1'b0;

      case (state_q)
         ST_RUN: begin
            // Abort has priority over a step due in the same cycle.
            if (ABORT) begin
               finish = 1'b1;
            end else if (tick) begin
               phase_d = phase_q + step_pos[2:0];
               pos_d   = pos_q + step_pos;
               steps_d = steps_q - STEPS_W'(1);
               if (steps_q == STEPS_W'(1)) begin
                  finish = 1'b1;
               end
            end
         end
         default: begin
            // IDLE and HOLD both accept commands; HOLD also runs its dwell.
            if (state_q == ST_HOLD) begin
               if (hold_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            if (accept) begin
               if (CMD_STEPS == '0) begin
                  // No motion; the dwell (if any) keeps counting.
                  done_d = 1'b1;
               end else begin
                  state_d    = ST_RUN;
                  dir_d      = CMD_DIR;
                  half_d     = CMD_HALF;
                  steps_d    = CMD_STEPS;
                  timer_load = 1'b1;
               end
            end
         end
      endcase

      if (finish) begin
         done_d = 1'b1;
         if (HOLD_CYCLES == 0) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
         end
      end
   end

   // Outputs are registered from next-state so they line up with state_q.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         pos_q   <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
         coils_q <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pos_q   <= pos_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         coils_q <= (state_d == ST_IDLE) ? 4'b0000 : phase_coils(phase_d);
         busy_q  <= (state_d == ST_RUN);
         ready_q <= (state_d != ST_RUN);
      end
   end

   // Latched command fields carry no reset; they are only read in RUN.
   always_ff @(posedge CLK) begin
      dir_q   <= dir_d;
      half_q  <= half_d;
      steps_q <= steps_d;
   end

   assign CMD_READY        = ready_q;
   assign BUSY             = busy_q;
   assign DONE             = done_q;
   assign POS              = pos_q;
   assign PHASE            = phase_q;
   assign {A1, B1, A2, B2} = coils_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
module tb_stepper_move_ctrl;

   localparam int HOLD = 4;
   localparam int MINP = 2;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               CMD_VALID = 1'b0;
   logic               CMD_READY;
   logic               CMD_DIR = 1'b0;
   logic               CMD_HALF = 1'b0;
   logic [15:0]        CMD_STEPS = '0;
   logic [15:0]        CMD_PERIOD = '0;
   logic               ABORT = 1'b0;
   logic               BUSY;
   logic               DONE;
   logic signed [23:0] POS;
   logic [2:0]         PHASE;
   logic               A1, B1, A2, B2;

   int total = 0;
   int bad   = 0;

   // Reference model: position/phase after the last completed move, and dwell.
   int                 m_phase = 0;
   logic signed [23:0] m_pos   = '0;
   bit                 m_hold  = 1'b0;
   int                 hold_left = 0;

   stepper_move_ctrl #(
      .STEPS_W     (16),
      .PERIOD_W    (16),
      .POS_W       (24),
      .MIN_PERIOD  (MINP),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CMD_VALID  (CMD_VALID),
      .CMD_READY  (CMD_READY),
      .CMD_DIR    (CMD_DIR),
      .CMD_HALF   (CMD_HALF),
      .CMD_STEPS  (CMD_STEPS),
      .CMD_PERIOD (CMD_PERIOD),
      .ABORT      (ABORT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .POS        (POS),
      .PHASE      (PHASE),
      .A1         (A1),
      .B1         (B1),
      .A2         (A2),
      .B2         (B2)
   );

   always #5 CLK = ~CLK;

   function automatic int mod8(input int v);
      return ((v % 8) + 8) % 8;
   endfunction

   // Each coil is on for three consecutive indices centred on its own phase.
   function automatic logic [3:0] coils_for(input int idx);
      logic a1, b1, a2, b2;
      a1 = (idx == 7) || (idx == 0) || (idx == 1);
      b1 = (idx >= 1) && (idx <= 3);
      a2 = (idx >= 3) && (idx <= 5);
      b2 = (idx >= 5) && (idx <= 7);
      return {a1, b1, a2, b2};
   endfunction

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ph, input logic signed [23:0] pos,
                          input bit on, input bit busy, input bit ready, input bit done);
      chk1({tag, ".phase"}, PHASE, ph);
      chk1({tag, ".pos"},   POS, pos);
      chk1({tag, ".coils"}, {A1, B1, A2, B2}, on ? coils_for(ph) : 4'b0000);
      chk1({tag, ".busy"},  BUSY, busy);
      chk1({tag, ".ready"}, CMD_READY, ready);
      chk1({tag, ".done"},  DONE, done);
   endtask

   // One clock while IDLE or HOLD; the dwell expires after HOLD cycles.
   task automatic step_dwell(input string tag, input bit exp_done);
      cyc();
      if (m_hold && hold_left > 0) hold_left--;
      else m_hold = 1'b0;
      chk_all(tag, m_phase, m_pos, m_hold, 1'b0, 1'b1, exp_done);
   endtask

   task automatic dwell_idle(input string tag);
      ABORT = 1'($urandom_range(0, 1));   // must be ignored outside RUN
      step_dwell(tag, 1'b0);
      ABORT = 1'b0;
   endtask

   task automatic wait_hold_out(input string tag);
      for (int i = 0; i < HOLD + 1 && m_hold; i++) dwell_idle(tag);
   endtask

   task automatic zero_cmd(input string tag);
      CMD_VALID  = 1'b1;
      CMD_STEPS  = '0;
      CMD_DIR    = 1'($urandom);
      CMD_HALF   = 1'($urandom);
      CMD_PERIOD = 16'($urandom_range(0, 7));
      step_dwell({tag, ".pulse"}, 1'b1);
      CMD_VALID = 1'b0;
      step_dwell({tag, ".after"}, 1'b0);
   endtask

   // ka > 0: ABORT is raised on the cycle step ka is due.
   task automatic do_move(input string tag, input bit dir, input bit half,
                          input int steps, input int period, input int ka);
      int p, d, end_m, ph0, taken, ph;
      bit fin;
      logic signed [23:0] pos0, pos;
      p     = (period < MINP) ? MINP : period;
      d     = (half ? 1 : 2) * (dir ? 1 : -1);
      end_m = (ka > 0) ? p * ka : p * steps;
      ph0   = m_phase;
      pos0  = m_pos;
      ph    = ph0;
      pos   = pos0;
      ABORT      = 1'b0;
      CMD_VALID  = 1'b1;
      CMD_DIR    = dir;
      CMD_HALF   = half;
      CMD_STEPS  = 16'(steps);
      CMD_PERIOD = 16'(period);
      cyc();
      for (int m = 0; m <= end_m; m++) begin
         if (m > 0) begin
            ABORT = (ka > 0) && (m == end_m);
            // Junk commands while busy must be ignored.
            CMD_VALID  = 1'($urandom_range(0, 1));
            CMD_DIR    = 1'($urandom);
            CMD_HALF   = 1'($urandom);
            CMD_STEPS  = 16'($urandom_range(0, 9));
            CMD_PERIOD = 16'($urandom_range(0, 9));
            cyc();
            ABORT = 1'b0;
         end
         fin   = (m == end_m);
         taken = (ka > 0 && fin) ? ka - 1 : m / p;
         ph    = mod8(ph0 + taken * d);
         pos   = pos0 + 24'(taken * d);
         chk_all(tag, ph, pos, 1'b1, !fin, fin, fin);
      end
      CMD_VALID = 1'b0;
      m_phase   = ph;
      m_pos     = pos;
      m_hold    = 1'b1;
      hold_left = HOLD - 1;
   endtask

   initial begin
      int nd, dir, half, steps, period, ka;

      // Reset state
      repeat (2) cyc();
      chk_all("reset", 0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      RST = 1'b0;
      cyc();
      chk_all("post_reset", 0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Forward half-steps, then dwell expiry to IDLE
      do_move("fwd_half", 1'b1, 1'b1, 3, 5, 0);
      wait_hold_out("hold1");

      // Reverse full-steps, period clamped, phase wraps below 0
      do_move("rev_full", 1'b0, 1'b0, 2, 1, 0);
      wait_hold_out("hold2");

      // Abort on the cycle step 3 is due
      do_move("abort", 1'b1, 1'b1, 10, 4, 3);
      wait_hold_out("hold3");

      // Zero-step command while idle
      zero_cmd("zero_idle");

      // New command during the dwell keeps coils energized
      do_move("pre_hold", 1'b1, 1'b0, 2, 3, 0);
      dwell_idle("dwell_c2");
      do_move("in_hold", 1'b1, 1'b1, 3, 2, 0);
      wait_hold_out("hold4");

      // Zero-step command during the dwell: dwell keeps running
      do_move("pre_zero", 1'b0, 1'b1, 1, 2, 0);
      zero_cmd("zero_hold");
      wait_hold_out("hold5");

      // Randomized moves
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            zero_cmd("rnd_zero");
         end else begin
            dir    = $urandom_range(0, 1);
            half   = $urandom_range(0, 1);
            steps  = $urandom_range(1, 6);
            period = $urandom_range(0, 5);
            ka     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, steps) : 0;
            do_move("rnd_move", 1'(dir), 1'(half), steps, period, ka);
         end
         nd = $urandom_range(0, 5);
         for (int j = 0; j < nd; j++) dwell_idle("rnd_dwell");
      end
      wait_hold_out("rnd_end");

      // Asynchronous reset in the middle of a move
      CMD_VALID  = 1'b1;
      CMD_DIR    = 1'b1;
      CMD_HALF   = 1'b1;
      CMD_STEPS  = 16'd10;
      CMD_PERIOD = 16'd4;
      cyc();
      CMD_VALID = 1'b0;
      repeat (6) cyc();
      RST = 1'b1;
      #1;
      chk_all("async_rst", 0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      m_phase = 0;
      m_pos   = '0;
      m_hold  = 1'b0;
      chk_all("rst_release", 0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge CLK);

      // Recovery move after reset
      do_move("recover", 1'b0, 1'b1, 2, 3, 0);
      wait_hold_out("hold6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
- Move sequencer for the unipolar stepper driver (outputs A1/A2/B1/B2).
- Replaces the free-running 2-bit counter + decoder pair with a command-driven controller.
- Accepts move commands (step count, direction, step period, half/full mode) over a valid/ready handshake.
- Steps the coil phase table at the programmed rate, tracks absolute position, holds torque for a dwell, then de-energizes the coils.

Parameters:
STEPS_W, 16, width of step-count field
PERIOD_W, 16, width of step-period field (clock cycles per step)
POS_W, 24, width of signed absolute position (half-step units)
MIN_PERIOD, 2, smallest accepted step period; smaller requests are clamped up to this
HOLD_CYCLES, 1000000, cycles coils stay energized after a move; 0 = de-energize immediately

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  controller can accept a command
CMD_DIR  in  1  1 = forward (phase index increments), 0 = reverse
CMD_HALF  in  1  1 = half-step (±1 index), 0 = full-step (±2 index)
CMD_STEPS  in  STEPS_W  number of steps to execute
CMD_PERIOD  in  PERIOD_W  cycles between steps
ABORT  in  1  stop the current move
BUSY  out  1  move in progress (state RUN)
DONE  out  1  one-cycle pulse at end of move, abort, or zero-step command
POS  out  POS_W  signed absolute position, half-step units
PHASE  out  3  current phase index 0..7
A1, B1, A2, B2  out  1 each  coil drives

Behaviour:
- All outputs registered. Reset (async, immediate, also mid-move): state IDLE, PHASE=0, POS=0, coils all 0, BUSY=0, DONE=0, CMD_READY=1.
- Phase table (index: energized coils): 0:A1, 1:A1+B1, 2:B1, 3:B1+A2, 4:A2, 5:A2+B2, 6:B2, 7:B2+A1. Index wraps modulo 8.
- Full-step mode moves the index by ±2 and preserves its parity.
- States:
  - IDLE: coils 0, CMD_READY=1.
  - RUN: coils = table[PHASE], CMD_READY=0, BUSY=1.
  - HOLD: coils = table[PHASE], CMD_READY=1, BUSY=0.
- Accept: command is taken on a rising edge with CMD_VALID & CMD_READY. Latch DIR, HALF, STEPS, and max(PERIOD, MIN_PERIOD).
- Zero-step command (CMD_STEPS=0): no motion; DONE high the next cycle; state unchanged (a running HOLD dwell continues).
- Command with STEPS>0:
  - Enter RUN the cycle after accept, step timer loaded with P. Coils energize at the current PHASE immediately.
  - Step k (1..N) occurs P·k cycles after RUN entry. Each step updates PHASE by ±1 or ±2 and POS by the same signed amount (POS wraps modulo 2^POS_W).
  - The cycle the Nth step appears on PHASE: state becomes HOLD, BUSY=0, DONE=1 for that one cycle.
- HOLD: counts HOLD_CYCLES, then goes to IDLE and coils go to 0. PHASE and POS are retained. A new accepted command in HOLD cancels the dwell and enters RUN without de-energizing.
- ABORT in RUN: next cycle go to HOLD with DONE=1. Any step due that same cycle is NOT taken; abort wins. ABORT in IDLE/HOLD is ignored.
- CMD_VALID while not ready: ignored; the command must be held by the source.

Decomposition:
- Shared package: phase-table constant (8 × 4-bit {A1,B1,A2,B2}), state encoding (IDLE/RUN/HOLD), MIN_PERIOD default.
- One sub-module: step_timer. Loadable down-counter of PERIOD_W bits; emits a one-cycle tick every P cycles while enabled; reload on load.
- The FSM, phase index, position and hold counter stay in stepper_move_ctrl.

Test Plan:
1. Reset → accept DIR=1 HALF=1 STEPS=3 PERIOD=5 at cycle T (HOLD_CYCLES=4) → coils A1 from T+1; PHASE 1,2,3 at T+6,T+11,T+16; DONE only at T+16; POS=3; coils 0 from T+20, state IDLE.
2. From PHASE=3/POS=3: DIR=0 HALF=0 STEPS=2 PERIOD=1 → period clamped to 2; PHASE 1 then 7 (wrap); POS=-1; coils A1+B1 then B2+A1.
3. STEPS=10 PERIOD=4, ABORT asserted on the cycle step 3 is due → PHASE advances only 2; DONE next cycle; state HOLD; POS=+2.
4. STEPS=0 in IDLE → DONE single pulse next cycle; coils stay 0; BUSY never set; CMD_READY stays 1.
5. New command accepted during HOLD dwell (cycle 2 of 4) → coils never drop to 0; RUN resumes from retained PHASE.
6. Assert RST mid-RUN → all coils 0, POS=0, PHASE=0, BUSY=0 immediately (asynchronously); after release, CMD_READY=1.
